tcp_ack_scheduler: RTL and testbench

//  Decides when the TCP RX path emits an ACK segment. Watches the in-order ack pointer and free window

---
 rtl/tcp_ack_pkg.sv | 19 +
 rtl/tcp_ack_if.sv | 24 ++
 rtl/tcp_delack_timer.sv | 29 ++
 rtl/tcp_ack_scheduler.sv | 151 +++++++++++++++
 tb/tb_tcp_ack_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_ack_pkg.sv
// tcp_ack_pkg: shared types and helpers for the TCP ACK scheduler.
// Build option TCP_ACK_DELAYED_EN enables ACK coalescing and the delayed-ACK timer.
package tcp_ack_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      REQ  = 2'd2
   } ack_state_e;

   localparam logic [15:0] WIN_MAX      = 16'hFFFF;
   localparam int          SEG_CNT_BITS = 4;

   // Advertised window without scaling: clamp to 16 bits
   function automatic logic [15:0] win_sat(input logic [31:0] w);
      return (w > 32'(WIN_MAX)) ? WIN_MAX : w[15:0];
   endfunction

endpackage

// File: rtl/tcp_ack_if.sv
// tcp_ack_if: ACK request handshake between the scheduler and the TX header builder.
// Unaffected by TCP_ACK_DELAYED_EN.
interface tcp_ack_if #(
   parameter int SEQ_BITS = 32
);
   logic                ack_req_o;
   logic                ack_grant_i;
   logic [SEQ_BITS-1:0] ack_seq_o;
   logic [15:0]         ack_win_o;

   modport master (
      output ack_req_o,
      output ack_seq_o,
      output ack_win_o,
      input  ack_grant_i
   );

   modport slave (
      input  ack_req_o,
      input  ack_seq_o,
      input  ack_win_o,
      output ack_grant_i
   );
endinterface

// File: rtl/tcp_delack_timer.sv
// tcp_delack_timer: saturating cycle counter with clear/enable and a done flag.
// Only instantiated when TCP_ACK_DELAYED_EN is defined.
module tcp_delack_timer #(
   parameter int MAX = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);
   localparam int W = $clog2(MAX + 1);
   localparam logic [W-1:0] LIM = W'(MAX);

   logic [W-1:0] cnt;

   // Count while enabled, hold at the limit, clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && cnt != LIM) begin
         cnt <= cnt + W'(1);
      end
   end

   assign done = (cnt == LIM);
endmodule

// File: rtl/tcp_ack_scheduler.sv
// tcp_ack_scheduler: decides when the RX path owes an ACK and requests it from TX.
// TCP_ACK_DELAYED_EN: coalesce segments / delay ACKs; undefined: ACK as soon as owed.
module tcp_ack_scheduler
   import tcp_ack_pkg::*;
#(
   parameter int SEQ_BITS          = 32,
   parameter int ACK_EVERY         = 2,
   parameter int DELACK_CYCLES     = 1000,
   parameter int WIN_UPDATE_THRESH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                conn_open_i,
   input  logic [SEQ_BITS-1:0] conn_seq_i,
   input  logic [SEQ_BITS-1:0] ack_seq_i,
   input  logic                ack_done_i,
   input  logic [31:0]         window_i,
   input  logic                seg_end_i,
   input  logic                ooo_i,
   tcp_ack_if.master           bus,
   output logic                ack_pending_o
);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_PEND = PEND;
   localparam logic [1:0] ST_REQ  = REQ;

   logic [1:0]          state;
   logic [1:0]          nxt;
   logic [SEQ_BITS-1:0] sent_ack;
   logic [SEQ_BITS-1:0] lat_seq;
   logic [SEQ_BITS-1:0] seq_q;
   logic [15:0]         win_q;
   logic [31:0]         prev_win;
   logic                req_q;
   logic                owe;
   logic                win_upd;
   logic                grant;
   logic                fire;

   assign owe     = ack_done_i && (ack_seq_i != sent_ack);
   assign win_upd = (prev_win < 32'(WIN_UPDATE_THRESH))
                 && (window_i >= 32'(WIN_UPDATE_THRESH));
   assign grant   = (state == ST_REQ) && bus.ack_grant_i;

`ifdef TCP_ACK_DELAYED_EN
   localparam bit DELAYED = 1'b1;

   typedef logic [SEG_CNT_BITS:0] seg_sum_t;
   localparam seg_sum_t ACK_N = seg_sum_t'(ACK_EVERY);

   logic [SEG_CNT_BITS-1:0] seg_cnt;
   seg_sum_t                seg_sum;
   logic                    tmr_done;

   assign seg_sum = seg_sum_t'(seg_cnt) + seg_sum_t'(seg_end_i);
   assign fire    = ooo_i || win_upd || tmr_done || (seg_sum >= ACK_N);

   tcp_delack_timer #(
      .MAX (DELACK_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != ST_PEND),
      .en    (state == ST_PEND),
      .done  (tmr_done)
   );

   // Segments seen while coalescing; zero outside PEND so entry starts fresh
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_cnt <= '0;
      end else if (state != ST_PEND) begin
         seg_cnt <= '0;
      end else if (seg_end_i && seg_cnt != '1) begin
         seg_cnt <= seg_cnt + SEG_CNT_BITS'(1);
      end
   end

   // Pending flag mirrors the PEND state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_pending_o <= 1'b0;
      end else begin
         ack_pending_o <= (nxt == ST_PEND);
      end
   end
`else
   localparam bit DELAYED = 1'b0;

   logic unused_cfg;

   assign fire          = 1'b0;
   assign ack_pending_o = 1'b0;
   assign unused_cfg    = ^{seg_end_i, ACK_EVERY[0], DELACK_CYCLES[0]};
`endif

   // Next state and the ack number to latch when a request starts
   always_comb begin
      nxt     = state;
      lat_seq = ack_seq_i;
      unique case (state)
         ST_IDLE: begin
            if (ooo_i || win_upd) begin
               nxt     = ST_REQ;
               lat_seq = owe ? ack_seq_i : sent_ack;
            end else if (owe) begin
               nxt = DELAYED ? ST_PEND : ST_REQ;
            end
         end
         ST_PEND: begin
            if (fire) nxt = ST_REQ;
         end
         ST_REQ: begin
            if (bus.ack_grant_i) begin
               nxt = (DELAYED && ack_seq_i != seq_q) ? ST_PEND : ST_IDLE;
            end
         end
         default: nxt = ST_IDLE;
      endcase
      if (conn_open_i) nxt = ST_IDLE;
   end

   // State, latched request fields and the last acknowledged pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         req_q    <= 1'b0;
         seq_q    <= '0;
         win_q    <= '0;
         sent_ack <= '0;
         prev_win <= '1;
      end else begin
         state    <= nxt;
         req_q    <= (nxt == ST_REQ);
         prev_win <= window_i;
         if (nxt == ST_REQ && state != ST_REQ) begin
            seq_q <= lat_seq;
            win_q <= win_sat(window_i);
         end
         if (conn_open_i) begin
            sent_ack <= conn_seq_i;
         end else if (grant) begin
            sent_ack <= seq_q;
         end
      end
   end

   assign bus.ack_req_o = req_q;
   assign bus.ack_seq_o = seq_q;
   assign bus.ack_win_o = win_q;
endmodule

// File: tb/tb_tcp_ack_scheduler.sv
// tb_tcp_ack_scheduler: directed, table-driven and randomized checks of tcp_ack_scheduler.
// Expectations follow TCP_ACK_DELAYED_EN when it is defined for the build.
module tb_tcp_ack_scheduler;
`ifdef TCP_ACK_DELAYED_EN
   localparam bit DEL = 1'b1;
`else
   localparam bit DEL = 1'b0;
`endif
   localparam int AE = 2;
   localparam int DC = 1000;
   localparam int WT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        conn_open = 1'b0;
   logic        ack_done = 1'b1;
   logic        seg_end = 1'b0;
   logic        ooo = 1'b0;
   logic [31:0] conn_seq = 32'd0;
   logic [31:0] ack_seq = 32'd0;
   logic [31:0] window = 32'd1000;
   logic        pending;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_req, m_pend;
   logic [31:0] m_sent, m_seq, m_prev;
   logic [15:0] m_win;
   int          m_segs, m_age;

   typedef struct {
      logic [31:0] win;
      bit          req;
      logic [15:0] exp;
   } wv_t;
   wv_t tbl[7];

   tcp_ack_if #(.SEQ_BITS(32)) bus();

   tcp_ack_scheduler #(
      .SEQ_BITS(32), .ACK_EVERY(AE),
      .DELACK_CYCLES(DC), .WIN_UPDATE_THRESH(WT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .conn_open_i(conn_open), .conn_seq_i(conn_seq),
      .ack_seq_i(ack_seq), .ack_done_i(ack_done),
      .window_i(window), .seg_end_i(seg_end), .ooo_i(ooo),
      .bus(bus), .ack_pending_o(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_seg();
      seg_end = 1'b1;
      tick();
      seg_end = 1'b0;
   endtask

   task automatic grant_one();
      bus.ack_grant_i = 1'b1;
      tick();
      bus.ack_grant_i = 1'b0;
   endtask

   task automatic drain();
      if (bus.ack_req_o) grant_one();
   endtask

   function automatic void model_reset();
      m_req = 0; m_pend = 0; m_sent = 0; m_seq = 0; m_win = 0;
      m_prev = 32'hFFFF_FFFF; m_segs = 0; m_age = 0;
   endfunction

   // One clock of the ACK rules, computed from the current inputs
   function automatic void model_step();
      logic owe, wu;
      logic [15:0] ws;
      owe = ack_done && (ack_seq != m_sent);
      wu  = (m_prev < WT) && (window >= WT);
      ws  = (window > 32'd65535) ? 16'hFFFF : window[15:0];
      if (conn_open) begin
         m_sent = conn_seq; m_req = 0; m_pend = 0;
      end else if (m_req) begin
         if (bus.ack_grant_i) begin
            m_sent = m_seq; m_req = 0;
            m_pend = DEL && (ack_seq != m_seq);
            m_segs = 0; m_age = 0;
         end
      end else if (m_pend) begin
         m_segs = (m_segs + int'(seg_end) > 15) ? 15 : m_segs + int'(seg_end);
         if (ooo || wu || m_segs >= AE || m_age == DC) begin
            m_pend = 0; m_req = 1; m_seq = ack_seq; m_win = ws;
         end else if (m_age < DC) begin
            m_age++;
         end
      end else if (ooo || wu) begin
         m_req = 1; m_seq = owe ? ack_seq : m_sent; m_win = ws;
      end else if (owe) begin
         if (DEL) begin
            m_pend = 1; m_segs = 0; m_age = 0;
         end else begin
            m_req = 1; m_seq = ack_seq; m_win = ws;
         end
      end
      m_prev = window;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lowp;
      bus.ack_grant_i = 1'b0;
      tbl[0] = '{32'd40,         1'b1, 16'd40};
      tbl[1] = '{32'd15,         1'b0, 16'd0};
      tbl[2] = '{32'd16,         1'b1, 16'd16};
      tbl[3] = '{32'd65535,      1'b1, 16'hFFFF};
      tbl[4] = '{32'd65536,      1'b1, 16'hFFFF};
      tbl[5] = '{32'd100000,     1'b1, 16'hFFFF};
      tbl[6] = '{32'hFFFF_FFFF,  1'b1, 16'hFFFF};

      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_req", bus.ack_req_o, 0);
      chk("rst_seq", bus.ack_seq_o, 0);
      chk("rst_win", bus.ack_win_o, 0);
      chk("rst_pend", pending, 0);

      // T1: coalesced ACK after two segments
      conn_open = 1; conn_seq = 1000; ack_seq = 1000;
      tick();
      conn_open = 0;
      chk("t1_open_noreq", bus.ack_req_o, 0);
      ack_seq = 1100;
      tick();
`ifdef TCP_ACK_DELAYED_EN
      chk("t1_pend", {bus.ack_req_o, pending}, 2'b01);
      pulse_seg();
      chk("t1_seg1_noreq", bus.ack_req_o, 0);
      pulse_seg();
`endif
      chk("t1_req", bus.ack_req_o, 1);
      chk("t1_seq", bus.ack_seq_o, 1100);
      chk("t1_win", bus.ack_win_o, 1000);
      grant_one();
      chk("t1_done", {bus.ack_req_o, pending}, 0);

      // T2: single segment, delayed-ACK timeout
      ack_seq = 1200;
      tick();
`ifdef TCP_ACK_DELAYED_EN
      chk("t2_pend_entry", pending, 1);
      n = 0; lowp = 0;
      seg_end = 1;
      while (!bus.ack_req_o && n < DC + 20) begin
         tick();
         seg_end = 0;
         n++;
         if (!bus.ack_req_o && !pending) lowp++;
      end
      chk("t2_latency", n, DC + 1);
      chk("t2_pending_held", lowp, 0);
`else
      chk("t2_req_now", {bus.ack_req_o, pending}, 2'b10);
`endif
      chk("t2_seq", bus.ack_seq_o, 1200);
      grant_one();

      // T3: duplicate ACK on out-of-order, held stable without grant
      ooo = 1;
      tick();
      ooo = 0;
      chk("t3_dup", {bus.ack_req_o, bus.ack_seq_o}, {1'b1, 32'd1200});
      window = 30;
      for (int i = 0; i < 5; i++) begin
         seg_end = (i % 2 == 0);
         ooo = (i == 2);
         tick();
         chk("t3_hold", {bus.ack_req_o, bus.ack_seq_o, bus.ack_win_o},
             {1'b1, 32'd1200, 16'd1000});
      end
      seg_end = 0; ooo = 0;
      grant_one();
      chk("t3_released", bus.ack_req_o, 0);
      ack_done = 0; ack_seq = 1300; ooo = 1;
      tick();
      ooo = 0;
      chk("t3_dup_undrained", {bus.ack_req_o, bus.ack_seq_o}, {1'b1, 32'd1200});
      ack_seq = 1200; ack_done = 1;
      grant_one();
      chk("t3_idle", {bus.ack_req_o, pending}, 0);

      // T4: window update table
      for (int i = 0; i < 7; i++) begin
         window = 8;
         tick();
         chk("t4_low_noreq", bus.ack_req_o, 0);
         window = tbl[i].win;
         tick();
         chk($sformatf("t4_req_%0d", i), bus.ack_req_o, tbl[i].req);
         if (tbl[i].req) chk($sformatf("t4_win_%0d", i), bus.ack_win_o, tbl[i].exp);
         drain();
         window = 1000;
         tick();
         drain();
      end

      // T5: pointer advances during REQ
      ack_seq = 1300;
      tick();
`ifdef TCP_ACK_DELAYED_EN
      chk("t5_pend", pending, 1);
      ooo = 1;
      tick();
      ooo = 0;
`endif
      chk("t5_req1", {bus.ack_req_o, bus.ack_seq_o}, {1'b1, 32'd1300});
      ack_seq = 1400;
      grant_one();
`ifdef TCP_ACK_DELAYED_EN
      chk("t5_after_grant", {bus.ack_req_o, pending}, 2'b01);
      pulse_seg();
      pulse_seg();
`else
      chk("t5_after_grant", {bus.ack_req_o, pending}, 2'b00);
      tick();
`endif
      chk("t5_req2", {bus.ack_req_o, bus.ack_seq_o, bus.ack_win_o},
          {1'b1, 32'd1400, 16'd1000});
      grant_one();
      chk("t5_done", bus.ack_req_o, 0);

      // T6: conn_open aborts a request and beats a same-cycle grant
      ooo = 1;
      tick();
      ooo = 0;
      chk("t6_req", bus.ack_req_o, 1);
      conn_open = 1; conn_seq = 5000; ack_seq = 5000; bus.ack_grant_i = 1;
      tick();
      conn_open = 0; bus.ack_grant_i = 0;
      chk("t6_abort", {bus.ack_req_o, pending}, 0);
      tick();
      chk("t6_idle", {bus.ack_req_o, pending}, 0);
      ooo = 1;
      tick();
      ooo = 0;
      chk("t6_dup_seq", {bus.ack_req_o, bus.ack_seq_o}, {1'b1, 32'd5000});
      #2 rst_n = 0;
      #1;
      chk("t6_async_rst", {bus.ack_req_o, bus.ack_seq_o, bus.ack_win_o, pending}, 0);

      // Randomized traffic against the reference model
      window = 1000; ack_done = 1;
      model_reset();
      tick();
      rst_n = 1;
      for (int c = 0; c < 4000; c++) begin
         conn_open = ($urandom_range(0, 99) < 2);
         if (conn_open) begin
            conn_seq = $urandom;
            ack_seq  = conn_seq;
         end else if ($urandom_range(0, 99) < 25) begin
            ack_seq = ack_seq + $urandom_range(1, 1460);
         end
         ack_done = ($urandom_range(0, 9) < 8);
         seg_end  = ($urandom_range(0, 9) < 3);
         ooo      = ($urandom_range(0, 99) < 3);
         bus.ack_grant_i = ($urandom_range(0, 9) < 4);
         if ($urandom_range(0, 9) < 2) begin
            case ($urandom_range(0, 3))
               0:       window = $urandom_range(0, 20);
               1:       window = $urandom_range(0, 40);
               2:       window = $urandom_range(0, 200000);
               default: window = $urandom;
            endcase
         end
         model_step();
         tick();
         chk("rand",
             {bus.ack_req_o, pending,
              m_req ? bus.ack_seq_o : 32'd0, m_req ? bus.ack_win_o : 16'd0},
             {m_req, m_pend, m_req ? m_seq : 32'd0, m_req ? m_win : 16'd0});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
